// File: rtl/value_chunker_if.sv
// ---------------------------------------------------------------------------
// value_chunker_if -- handshake bundle for value_chunker.
//   Input side : in_valid/in_ready carry one 8-bit word (in_val) plus the
//                extension mode the consumer will apply (is_sign_ext).
//   Output side: chunk_valid/chunk_ready carry one CHUNK_WIDTH-bit chunk at a
//                time with its index, a last flag and the word's chunk count.
//   slave  : the chunker itself.
//   master : whoever feeds words in and drains chunks out.
// ---------------------------------------------------------------------------
interface value_chunker_if #(
   parameter int CHUNK_WIDTH = 2
);
   logic                   in_valid;
   logic                   in_ready;
   logic [7:0]             in_val;
   logic                   is_sign_ext;
   logic                   chunk_valid;
   logic                   chunk_ready;
   logic [CHUNK_WIDTH-1:0] chunk;
   logic [2:0]             chunk_idx;
   logic                   chunk_last;
   logic [3:0]             num_chunks;

   modport slave (
      input  in_valid, in_val, is_sign_ext, chunk_ready,
      output in_ready, chunk_valid, chunk, chunk_idx, chunk_last, num_chunks
   );

   modport master (
      output in_valid, in_val, is_sign_ext, chunk_ready,
      input  in_ready, chunk_valid, chunk, chunk_idx, chunk_last, num_chunks
   );
endinterface

// File: rtl/value_chunker.sv
// ---------------------------------------------------------------------------
// value_chunker -- splits an 8-bit value into the shortest LSB-first run of
// CHUNK_WIDTH-bit chunks that an immediate extender (sign or zero mode)
// rebuilds into the original value.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : value_chunker_if.slave (word in, chunks out, valid/ready both)
// One word is held at a time; the next word is accepted only after the last
// chunk has been taken and the block has returned to IDLE.
// ---------------------------------------------------------------------------
module value_chunker #(
   parameter int CHUNK_WIDTH = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   value_chunker_if.slave bus
);
   localparam int MAX_CHUNKS = 8 / CHUNK_WIDTH;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

   logic [0:0] state_q, state_d;
   logic [7:0] val_q, val_d;
   logic [3:0] num_q, num_d;
   logic [2:0] idx_q, idx_d;
   logic [3:0] k_min;
   logic       last;

   // True when the low nb bits of v, extended back to 8 bits, reproduce v.
   function automatic logic fits(input logic [7:0] v, input int nb,
                                 input logic sgn);
      logic [7:0] e;
      e = '0;
      for (int b = 0; b < 8; b++) begin
         if (b < nb) e[b] = v[b];
         else        e[b] = sgn & v[nb-1];
      end
      return e == v;
   endfunction

   // Scan from widest to narrowest so the last hit is the smallest k.
   // k = MAX_CHUNKS covers all 8 bits, so the default is always correct.
   always_comb begin
      k_min = 4'(MAX_CHUNKS);
      for (int k = MAX_CHUNKS; k >= 1; k--) begin
         if (fits(bus.in_val, k * CHUNK_WIDTH, bus.is_sign_ext))
            k_min = 4'(k);
      end
   end

   assign last = (state_q == S_SEND) && ({1'b0, idx_q} == num_q - 4'd1);

   always_comb begin
      state_d = state_q;
      val_d   = val_q;
      num_d   = num_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               state_d = S_SEND;
               val_d   = bus.in_val;
               num_d   = k_min;
               idx_d   = 3'd0;
            end
         end
         default: begin
            if (bus.chunk_ready) begin
               if (last) state_d = S_IDLE;
               else      idx_d   = idx_q + 3'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         val_q   <= '0;
         num_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         val_q   <= val_d;
         num_q   <= num_d;
         idx_q   <= idx_d;
      end
   end

   // Outputs depend only on registered state: no in_valid -> chunk_valid or
   // chunk_ready -> in_ready combinational path.
   assign bus.in_ready    = (state_q == S_IDLE);
   assign bus.chunk_valid = (state_q == S_SEND);
   assign bus.chunk       = CHUNK_WIDTH'(val_q >> (int'(idx_q) * CHUNK_WIDTH));
   assign bus.chunk_idx   = idx_q;
   assign bus.chunk_last  = last;
   assign bus.num_chunks  = num_q;
endmodule

// File: tb/tb_value_chunker.sv
module tb_value_chunker;
   logic clk = 1'b0;
   logic rst_n  = 1'b1;   // sweep instances
   logic rst2_n = 1'b1;   // directed CHUNK_WIDTH=2 instance
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   // ---------------- directed instance, CHUNK_WIDTH = 2 ----------------
   value_chunker_if #(.CHUNK_WIDTH(2)) vif ();
   value_chunker #(.CHUNK_WIDTH(2)) u_dut (.clk(clk), .rst_n(rst2_n), .bus(vif.slave));

   // ---------------- sweep instances, CHUNK_WIDTH = 1,2,4,8 -------------
   logic       sw_in_valid = 1'b0;
   logic [7:0] sw_in_val   = '0;
   logic       sw_sign     = 1'b0;
   logic [3:0] sw_cv, sw_ir, sw_last;
   logic [7:0] sw_chunk [4];
   logic [2:0] sw_idx   [4];
   logic [3:0] sw_num   [4];

   for (genvar g = 0; g < 4; g++) begin : g_sw
      localparam int CW = 1 << g;
      value_chunker_if #(.CHUNK_WIDTH(CW)) ifc ();
      value_chunker #(.CHUNK_WIDTH(CW)) u_dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));
      assign ifc.in_valid    = sw_in_valid;
      assign ifc.in_val      = sw_in_val;
      assign ifc.is_sign_ext = sw_sign;
      assign ifc.chunk_ready = 1'b1;
      assign sw_cv[g]    = ifc.chunk_valid;
      assign sw_ir[g]    = ifc.in_ready;
      assign sw_last[g]  = ifc.chunk_last;
      assign sw_chunk[g] = 8'(ifc.chunk);
      assign sw_idx[g]   = ifc.chunk_idx;
      assign sw_num[g]   = ifc.num_chunks;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Extend the low nb bits of v to 8 bits, shift-based.
   function automatic logic [7:0] ext8(input logic [7:0] v, input int nb, input logic s);
      logic [7:0] t;
      logic [7:0] r;
      t = v << (8 - nb);
      if (s) r = 8'($signed(t) >>> (8 - nb));
      else   r = t >> (8 - nb);
      return r;
   endfunction

   // One word through the CW=2 instance with chunk_ready held high.
   task automatic run_vec(input logic [7:0] v, input logic s, input int n);
      logic [7:0] sh;
      @(negedge clk);
      chk($sformatf("in_ready_idle v=%02h", v), vif.in_ready, 1);
      vif.in_valid = 1'b1; vif.in_val = v; vif.is_sign_ext = s; vif.chunk_ready = 1'b1;
      @(negedge clk);
      vif.in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         sh = v >> (2 * i);
         chk($sformatf("cvalid v=%02h s=%0d i=%0d", v, s, i), vif.chunk_valid, 1);
         chk($sformatf("chunk v=%02h s=%0d i=%0d", v, s, i), vif.chunk, sh[1:0]);
         chk($sformatf("idx v=%02h s=%0d i=%0d", v, s, i), vif.chunk_idx, i);
         chk($sformatf("last v=%02h s=%0d i=%0d", v, s, i), vif.chunk_last, (i == n - 1));
         chk($sformatf("num v=%02h s=%0d", v, s), vif.num_chunks, n);
         chk($sformatf("in_ready_busy v=%02h", v), vif.in_ready, 0);
         @(negedge clk);
      end
      chk($sformatf("done_cvalid v=%02h s=%0d", v, s), vif.chunk_valid, 0);
      chk($sformatf("done_in_ready v=%02h s=%0d", v, s), vif.in_ready, 1);
   endtask

   typedef struct {
      logic [7:0] val;
      logic       sgn;
      int         n;
   } vec_t;

   vec_t tbl [15];
   int   bp  [7];

   initial begin
      logic [7:0] sh, v;
      logic       s;
      int         eidx, cyc, n, cw;
      logic [7:0] acc  [4];
      int         cnt  [4];
      logic [3:0] numg [4];
      bit         seqok[4];
      bit         plast[4];

      tbl[0]  = '{8'h05, 1'b0, 2};
      tbl[1]  = '{8'hFE, 1'b1, 1};
      tbl[2]  = '{8'hFE, 1'b0, 4};
      tbl[3]  = '{8'h02, 1'b1, 2};
      tbl[4]  = '{8'h00, 1'b1, 1};
      tbl[5]  = '{8'h00, 1'b0, 1};
      tbl[6]  = '{8'h7F, 1'b1, 4};
      tbl[7]  = '{8'h80, 1'b1, 4};
      tbl[8]  = '{8'h80, 1'b0, 4};
      tbl[9]  = '{8'hFF, 1'b1, 1};
      tbl[10] = '{8'hFF, 1'b0, 4};
      tbl[11] = '{8'h03, 1'b0, 1};
      tbl[12] = '{8'h03, 1'b1, 2};
      tbl[13] = '{8'hE0, 1'b1, 3};
      tbl[14] = '{8'h30, 1'b0, 3};
      bp = '{0, 0, 1, 0, 1, 1, 1};

      vif.in_valid = 1'b0; vif.in_val = '0; vif.is_sign_ext = 1'b0; vif.chunk_ready = 1'b1;

      // ---- reset ----
      #1 rst_n = 1'b0; rst2_n = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("rst_in_ready", vif.in_ready, 1);
      chk("rst_cvalid", vif.chunk_valid, 0);
      chk("rst_chunk", vif.chunk, 0);
      chk("rst_idx", vif.chunk_idx, 0);
      chk("rst_last", vif.chunk_last, 0);
      chk("rst_num", vif.num_chunks, 0);
      rst_n = 1'b1; rst2_n = 1'b1;

      // ---- table vectors ----
      foreach (tbl[i]) run_vec(tbl[i].val, tbl[i].sgn, tbl[i].n);

      // ---- backpressure, in_valid asserted while busy ----
      @(negedge clk);
      vif.in_valid = 1'b1; vif.in_val = 8'hFE; vif.is_sign_ext = 1'b0; vif.chunk_ready = 1'b0;
      @(negedge clk);
      vif.in_val = 8'h05;
      eidx = 0;
      for (int c = 0; c < 7; c++) begin
         vif.chunk_ready = bp[c][0];
         vif.in_valid    = (c < 6);
         sh = 8'hFE >> (2 * eidx);
         chk($sformatf("bp_in_ready c=%0d", c), vif.in_ready, 0);
         chk($sformatf("bp_cvalid c=%0d", c), vif.chunk_valid, 1);
         chk($sformatf("bp_idx c=%0d", c), vif.chunk_idx, eidx);
         chk($sformatf("bp_chunk c=%0d", c), vif.chunk, sh[1:0]);
         chk($sformatf("bp_last c=%0d", c), vif.chunk_last, (eidx == 3));
         chk($sformatf("bp_num c=%0d", c), vif.num_chunks, 4);
         if (bp[c] != 0) eidx++;
         @(negedge clk);
      end
      vif.in_valid = 1'b0; vif.chunk_ready = 1'b1;
      chk("bp_done_cvalid", vif.chunk_valid, 0);
      chk("bp_done_in_ready", vif.in_ready, 1);

      // ---- reset mid-stream ----
      @(negedge clk);
      vif.in_valid = 1'b1; vif.in_val = 8'hFE; vif.is_sign_ext = 1'b0;
      @(negedge clk);
      vif.in_valid = 1'b0;
      @(negedge clk);
      chk("mid_idx_before_rst", vif.chunk_idx, 1);
      rst2_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", vif.in_ready, 1);
      chk("mid_rst_cvalid", vif.chunk_valid, 0);
      chk("mid_rst_chunk", vif.chunk, 0);
      chk("mid_rst_idx", vif.chunk_idx, 0);
      chk("mid_rst_last", vif.chunk_last, 0);
      chk("mid_rst_num", vif.num_chunks, 0);
      @(negedge clk);
      rst2_n = 1'b1;
      run_vec(8'h05, 1'b0, 2);

      // ---- sweep all values, both modes, all chunk widths ----
      for (int vi = 0; vi < 256; vi++) begin
         for (int si = 0; si < 2; si++) begin
            v = 8'(vi); s = si[0];
            @(negedge clk);
            chk($sformatf("sw_ready v=%02h", v), sw_ir, 4'hF);
            sw_in_valid = 1'b1; sw_in_val = v; sw_sign = s;
            @(negedge clk);
            sw_in_valid = 1'b0;
            for (int g = 0; g < 4; g++) begin
               acc[g] = '0; cnt[g] = 0; numg[g] = '0; seqok[g] = 1'b1; plast[g] = 1'b0;
            end
            cyc = 0;
            while (sw_cv != 4'h0 && cyc < 12) begin
               for (int g = 0; g < 4; g++) begin
                  if (sw_cv[g]) begin
                     acc[g] = acc[g] | (sw_chunk[g] << (cnt[g] * (1 << g)));
                     if (plast[g] || sw_idx[g] != 3'(cnt[g])) seqok[g] = 1'b0;
                     if (cnt[g] > 0 && sw_num[g] != numg[g]) seqok[g] = 1'b0;
                     numg[g]  = sw_num[g];
                     plast[g] = sw_last[g];
                     cnt[g]++;
                  end
               end
               @(negedge clk);
               cyc++;
            end
            chk($sformatf("sw_timeout v=%02h s=%0d", v, s), sw_cv, 4'h0);
            for (int g = 0; g < 4; g++) begin
               cw = 1 << g;
               n  = cnt[g];
               chk($sformatf("sw_count w=%0d v=%02h s=%0d", cw, v, s), (n > 0 && n <= 8 / cw), 1);
               if (n > 0 && n <= 8 / cw) begin
                  chk($sformatf("sw_seq w=%0d v=%02h s=%0d", cw, v, s), {seqok[g], plast[g]}, 2'b11);
                  chk($sformatf("sw_num w=%0d v=%02h s=%0d", cw, v, s), numg[g], n);
                  chk($sformatf("sw_rebuild w=%0d v=%02h s=%0d", cw, v, s), ext8(acc[g], n * cw, s), v);
                  chk($sformatf("sw_minimal w=%0d v=%02h s=%0d", cw, v, s),
                      (n == 1) || (ext8(acc[g], (n - 1) * cw, s) != v), 1);
               end
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/value_chunker.md
Name: value_chunker

Overview:
- Inverse of the immediate extender: takes an 8-bit value plus a sign/zero mode and emits the shortest LSB-first sequence of CHUNK_WIDTH-bit chunks that the extender rebuilds into the same 8-bit value.
- Sits between the datapath and the instruction/immediate packing logic. Used to check whether a value fits a narrow immediate field, and to split wide constants into multi-instruction immediates.
- Valid/ready on both sides; one word in flight at a time.

Parameters:
- CHUNK_WIDTH, 2, bits per emitted chunk. Legal values are 1, 2, 4, 8 (must divide 8).
- MAX_CHUNKS, 8/CHUNK_WIDTH, derived; not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_val/is_sign_ext are valid.
- in_ready  output  1  block can accept a word.
- in_val  input  8  value to split.
- is_sign_ext  input  1  1 = the consumer sign-extends, 0 = the consumer zero-extends.
- chunk_valid  output  1  chunk is valid.
- chunk_ready  input  1  consumer accepts the chunk.
- chunk  output  CHUNK_WIDTH  current chunk, LSB-first.
- chunk_idx  output  3  index of the current chunk, starting at 0.
- chunk_last  output  1  current chunk is the final one.
- num_chunks  output  4  chunk count for the held word; valid while chunk_valid = 1.

Behaviour:
- Reset (async assert, sync deassert to clk):
  - state = IDLE.
  - in_ready = 1; chunk_valid = 0; chunk = 0; chunk_idx = 0; chunk_last = 0; num_chunks = 0.
  - All internal registers cleared.
- States:
  - IDLE: in_ready = 1, chunk_valid = 0.
  - SEND: in_ready = 0, chunk_valid = 1.
- IDLE -> SEND on in_valid & in_ready. On that edge the block registers:
  - in_val;
  - num_chunks = k, the smallest k in 1..MAX_CHUNKS such that extending the low k*CHUNK_WIDTH bits of in_val (sign or zero, per is_sign_ext) to 8 bits equals in_val. k = MAX_CHUNKS always satisfies this, so k is always defined.
  - chunk_idx = 0.
- Latency: chunk 0 is presented the cycle after the input handshake.
- chunk = in_val[chunk_idx*CHUNK_WIDTH +: CHUNK_WIDTH]. chunk_last = (chunk_idx == num_chunks-1).
- In SEND, on chunk_valid & chunk_ready:
  - not last: chunk_idx increments;
  - last: go to IDLE, chunk_valid drops, in_ready rises the next cycle. No same-cycle accept of the next word.
- Backpressure: while chunk_ready = 0, chunk, chunk_idx, chunk_last and num_chunks hold stable and chunk_valid stays 1.
- Input in IDLE with in_valid = 0: no state change. Input in SEND is ignored (in_ready = 0).
- Sign mode: the top bit of the final chunk always equals in_val[7]. This guarantees correct sign extension.
- Zero mode: all bits above the final chunk are 0.
- CHUNK_WIDTH = 8: always one chunk equal to in_val, with chunk_last = 1.
- Reset mid-SEND: the word is discarded with no partial completion; the block comes out of reset in IDLE.
- No combinational path from in_valid to chunk_valid, or from chunk_ready to in_ready.

Test Plan (CHUNK_WIDTH = 2 unless stated):
- in_val = 0x05, zero mode, chunk_ready = 1 -> num_chunks = 2; chunks 2'b01 (idx 0), 2'b01 (idx 1, last); in_ready high 1 cycle after the last.
- in_val = 0xFE, sign mode -> num_chunks = 1; single chunk 2'b10 with chunk_last = 1. Same value in zero mode -> 4 chunks: 10, 11, 11, 11.
- in_val = 0x02, sign mode -> num_chunks = 2; chunks 10, 00. Confirms the top chunk bit is 0 for a positive value. in_val = 0x00 in either mode -> 1 chunk, 00.
- Backpressure: 0xFE in zero mode, chunk_ready toggled 0,0,1,0,1,1,1 -> each chunk holds while ready = 0; exactly 4 handshakes; in_valid asserted during SEND is ignored (in_ready = 0).
- Reset mid-stream: 0xFE in zero mode, rst_n low after chunk 1 -> outputs are at reset values immediately; after release, 0x05 in zero mode streams normally.
- Random sweep over all 256 values × both modes × CHUNK_WIDTH ∈ {1, 2, 4, 8} -> reassembling the chunks and extending them to 8 bits equals in_val, and num_chunks is minimal (k-1 chunks fail the check).
